asynchronous_fifo_read_port: RTL and testbench

//  Read-domain half of the dual-clock FIFO, successor to the single-mode read controller.

---
 rtl/asynchronous_fifo_pkg.sv | 37 +++
 rtl/asynchronous_fifo_read_port_if.sv | 25 ++
 rtl/asynchronous_fifo_read_port_sync.sv | 26 ++
 rtl/asynchronous_fifo_read_port.sv | 201 ++++++++++++++++++++
 tb/tb_asynchronous_fifo_read_port.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/asynchronous_fifo_pkg.sv
// Types and helpers shared by the read and write ports of the dual-clock FIFO:
// Gray/binary conversion, pointer-width helpers and the FWFT prefetch state.
package asynchronous_fifo_pkg;

    localparam int MAX_POINTER_WIDTH = 32;

    typedef logic [MAX_POINTER_WIDTH-1:0] pointer_word_t;

    typedef enum logic [1:0] {
        PF_EMPTY = 2'd0,
        PF_ONE   = 2'd1,
        PF_TWO   = 2'd2
    } prefetch_state_e;

    function automatic int address_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit distinguishes full from empty when the addresses match.
    function automatic int pointer_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic pointer_word_t binary_to_gray(input pointer_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic pointer_word_t gray_to_binary(input pointer_word_t gray);
        pointer_word_t bin;
        bin[MAX_POINTER_WIDTH-1] = gray[MAX_POINTER_WIDTH-1];
        for (int i = MAX_POINTER_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/asynchronous_fifo_read_port_if.sv
// Consumer-facing bundle of the FIFO read port: data handshake plus status flags.
interface asynchronous_fifo_read_port_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int POINTER_WIDTH = 13
);

    logic                     read_ready;
    logic [DATA_WIDTH-1:0]    read_data;
    logic                     read_data_valid;
    logic                     empty;
    logic [POINTER_WIDTH-1:0] read_level;
    logic                     almost_empty;
    logic                     underflow;

    modport master (
        input  read_ready,
        output read_data, read_data_valid, empty, read_level, almost_empty, underflow
    );

    modport slave (
        output read_ready,
        input  read_data, read_data_valid, empty, read_level, almost_empty, underflow
    );

endinterface

// File: rtl/asynchronous_fifo_read_port_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module gray_pointer_synchronizer #(
    parameter int WIDTH  = 13,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_sync
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] sync_chain;

    // NOTE: flops always take non-blocking assignments so every stage samples
    // the previous stage's old value and the chain really is STAGES deep.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[STAGES-2:0], gray_in};
        end
    end

    assign gray_sync = sync_chain[STAGES-1];

endmodule

// File: rtl/asynchronous_fifo_read_port.sv
// Read-domain half of the dual-clock FIFO: pointer sync, RAM read control and
// FWFT or request/response delivery. ASYNC_FIFO_READ_LEVEL_EN builds read_level/almost_empty.
module asynchronous_fifo_read_port
    import asynchronous_fifo_pkg::*;
#(
    parameter int DATA_WIDTH              = 16,
    parameter int DATA_DEPTH              = 4096,
    parameter int FIRST_WORD_FALL_THROUGH = 1,
    parameter int SYNC_STAGES             = 2,
    parameter int ALMOST_EMPTY_THRESHOLD  = 4
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic [pointer_width(DATA_DEPTH)-1:0]       write_pointer_gray,
    input  logic [DATA_WIDTH-1:0]                      memory_read_data,
    output logic                                       memory_read_enable,
    output logic [address_width(DATA_DEPTH)-1:0]       memory_read_address,
    output logic [pointer_width(DATA_DEPTH)-1:0]       read_pointer_gray,
    asynchronous_fifo_read_port_if.master              read_port
);

    localparam int AW = address_width(DATA_DEPTH);
    localparam int PW = pointer_width(DATA_DEPTH);

    logic [PW-1:0] write_pointer_sync_gray;
    logic [PW-1:0] write_pointer_sync;
    logic [PW-1:0] read_pointer;
    logic [PW-1:0] read_pointer_next;
    pointer_word_t write_pointer_wide;
    pointer_word_t read_gray_wide;
    logic          unused_upper_bits;
    logic          memory_empty;
    logic          read_issue;
    logic          read_in_flight;

`ifdef ASYNC_FIFO_READ_LEVEL_EN
    logic [1:0]    pipeline_words;
`endif

    gray_pointer_synchronizer #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_write_pointer_sync (
        .clock     (clock),
        .reset_n   (reset_n),
        .gray_in   (write_pointer_gray),
        .gray_sync (write_pointer_sync_gray)
    );

    assign write_pointer_wide  = gray_to_binary(pointer_word_t'(write_pointer_sync_gray));
    assign write_pointer_sync  = write_pointer_wide[PW-1:0];
    assign read_pointer_next   = read_pointer + PW'(read_issue);
    assign read_gray_wide      = binary_to_gray(pointer_word_t'(read_pointer_next));
    assign unused_upper_bits   = ^{write_pointer_wide[MAX_POINTER_WIDTH-1:PW],
                                   read_gray_wide[MAX_POINTER_WIDTH-1:PW]};

    assign memory_empty        = (write_pointer_sync == read_pointer);
    assign memory_read_enable  = read_issue;
    assign memory_read_address = read_pointer[AW-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_pointer      <= '0;
            read_pointer_gray <= '0;
            read_in_flight    <= 1'b0;
        end else begin
            read_pointer      <= read_pointer_next;
            read_pointer_gray <= read_gray_wide[PW-1:0];
            read_in_flight    <= read_issue;
        end
    end

    if (FIRST_WORD_FALL_THROUGH != 0) begin : g_fwft
        prefetch_state_e       state;
        logic [DATA_WIDTH-1:0] output_word;
        logic [DATA_WIDTH-1:0] skid_word;
        logic                  output_valid;
        logic [1:0]            held_words;
        logic                  pop;

        assign held_words = (state == PF_TWO) ? 2'd2 : ((state == PF_ONE) ? 2'd1 : 2'd0);
        assign pop        = read_port.read_ready && output_valid;
        // A word leaving this cycle frees its slot, which keeps one word per clock flowing.
        assign read_issue = !memory_empty &&
                            ((held_words + 2'(read_in_flight) - 2'(pop)) < 2'd2);

`ifdef ASYNC_FIFO_READ_LEVEL_EN
        assign pipeline_words = held_words + 2'(read_in_flight) - 2'(pop) + 2'(read_issue);
`endif

        // NOTE: the buffered words are reset along with the state so a reset in
        // mid-stream can never present a stale word once valid rises again.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                state        <= PF_EMPTY;
                output_valid <= 1'b0;
                output_word  <= '0;
                skid_word    <= '0;
            end else begin
                case (state)
                    PF_EMPTY: begin
                        if (read_in_flight) begin
                            output_word  <= memory_read_data;
                            output_valid <= 1'b1;
                            state        <= PF_ONE;
                        end
                    end
                    PF_ONE: begin
                        if (pop) begin
                            if (read_in_flight) begin
                                output_word <= memory_read_data;
                            end else begin
                                output_valid <= 1'b0;
                                state        <= PF_EMPTY;
                            end
                        end else if (read_in_flight) begin
                            skid_word <= memory_read_data;
                            state     <= PF_TWO;
                        end
                    end
                    PF_TWO: begin
                        if (pop) begin
                            output_word <= skid_word;
                            if (read_in_flight) begin
                                skid_word <= memory_read_data;
                            end else begin
                                state <= PF_ONE;
                            end
                        end
                    end
                    default: begin
                        output_valid <= 1'b0;
                        state        <= PF_EMPTY;
                    end
                endcase
            end
        end

        assign read_port.read_data       = output_word;
        assign read_port.read_data_valid = output_valid;
        assign read_port.empty           = !output_valid;
        assign read_port.underflow       = 1'b0;
    end else begin : g_standard
        logic [DATA_WIDTH-1:0] output_word;
        logic                  output_valid;
        logic                  underflow_pulse;

        assign read_issue = read_port.read_ready && !memory_empty;

`ifdef ASYNC_FIFO_READ_LEVEL_EN
        assign pipeline_words = 2'd0;
`endif

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                output_word     <= '0;
                output_valid    <= 1'b0;
                underflow_pulse <= 1'b0;
            end else begin
                output_valid    <= read_in_flight;
                underflow_pulse <= read_port.read_ready && memory_empty;
                if (read_in_flight) begin
                    output_word <= memory_read_data;
                end
            end
        end

        assign read_port.read_data       = output_word;
        assign read_port.read_data_valid = output_valid;
        assign read_port.empty           = memory_empty;
        assign read_port.underflow       = underflow_pulse;
    end

`ifdef ASYNC_FIFO_READ_LEVEL_EN
    logic [PW-1:0] level_next;
    logic [PW-1:0] level_q;
    logic          almost_empty_q;

    // Level after this edge: words still in RAM plus words in the prefetch path.
    assign level_next = write_pointer_sync - read_pointer_next + PW'(pipeline_words);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q        <= '0;
            almost_empty_q <= 1'b1;
        end else begin
            level_q        <= level_next;
            almost_empty_q <= (level_next <= PW'(ALMOST_EMPTY_THRESHOLD));
        end
    end

    assign read_port.read_level   = level_q;
    assign read_port.almost_empty = almost_empty_q;
`else
    localparam int unused_threshold = ALMOST_EMPTY_THRESHOLD;

    assign read_port.read_level   = '0;
    assign read_port.almost_empty = read_port.empty;
`endif

endmodule

// File: tb/tb_asynchronous_fifo_read_port.sv
// Directed bench for the FIFO read port: one FWFT and one standard-mode instance, DEPTH=8.
module tb_asynchronous_fifo_read_port;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int PW    = 4;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;

    logic [PW-1:0] wgray_f, wgray_s, rgray_f, rgray_s;
    logic [DW-1:0] rdata_f, rdata_s;
    logic          mre_f, mre_s;
    logic [AW-1:0] addr_f, addr_s;

    logic [DW-1:0] mem_f [DEPTH];
    logic [DW-1:0] mem_s [DEPTH];
    logic [AW-1:0] addr_log [$];

    int wptr_f = 0;
    int wptr_s = 0;
    int compared = 0;
    int mismatched = 0;

    asynchronous_fifo_read_port_if #(.DATA_WIDTH(DW), .POINTER_WIDTH(PW)) port_f ();
    asynchronous_fifo_read_port_if #(.DATA_WIDTH(DW), .POINTER_WIDTH(PW)) port_s ();

    asynchronous_fifo_read_port #(
        .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FIRST_WORD_FALL_THROUGH(1),
        .SYNC_STAGES(2), .ALMOST_EMPTY_THRESHOLD(4)
    ) dut_fwft (
        .clock(clock), .reset_n(reset_n), .write_pointer_gray(wgray_f),
        .memory_read_data(rdata_f), .memory_read_enable(mre_f),
        .memory_read_address(addr_f), .read_pointer_gray(rgray_f), .read_port(port_f)
    );

    asynchronous_fifo_read_port #(
        .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .FIRST_WORD_FALL_THROUGH(0),
        .SYNC_STAGES(2), .ALMOST_EMPTY_THRESHOLD(4)
    ) dut_std (
        .clock(clock), .reset_n(reset_n), .write_pointer_gray(wgray_s),
        .memory_read_data(rdata_s), .memory_read_enable(mre_s),
        .memory_read_address(addr_s), .read_pointer_gray(rgray_s), .read_port(port_s)
    );

    always #5 clock = ~clock;

    // Synchronous RAM models with one cycle of read latency.
    always @(posedge clock) begin
        if (mre_f) begin
            rdata_f <= mem_f[addr_f];
            addr_log.push_back(addr_f);
        end
        if (mre_s) rdata_s <= mem_s[addr_s];
    end

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] exp_level(input int words);
`ifdef ASYNC_FIFO_READ_LEVEL_EN
        return 32'(words);
`else
        return 32'(words * 0);
`endif
    endfunction

    function automatic logic exp_almost(input int words, input logic empty_expected);
`ifdef ASYNC_FIFO_READ_LEVEL_EN
        return (words <= 4);
`else
        return empty_expected;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_fwft(input logic [DW-1:0] word);
        mem_f[wptr_f % DEPTH] = word;
        wptr_f++;
        wgray_f = to_gray(PW'(wptr_f));
    endtask

    task automatic write_std(input logic [DW-1:0] word);
        mem_s[wptr_s % DEPTH] = word;
        wptr_s++;
        wgray_s = to_gray(PW'(wptr_s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int got;
        int first;
        int last;
        int written;
        logic gray_checked;

        wgray_f = '0;
        wgray_s = '0;
        port_f.read_ready = 1'b0;
        port_s.read_ready = 1'b0;
        repeat (2) tick();

        // Reset state.
        check("rst_valid",     port_f.read_data_valid, 0);
        check("rst_empty",     port_f.empty, 1);
        check("rst_level",     port_f.read_level, 0);
        check("rst_almost",    port_f.almost_empty, 1);
        check("rst_rgray",     rgray_f, 0);
        check("rst_mre",       mre_f, 0);
        check("rst_std_empty", port_s.empty, 1);
        check("rst_std_uflow", port_s.underflow, 0);
        reset_n = 1'b1;
        tick();

        // 1: single word, first-word latency SYNC_STAGES+2.
        write_fwft(16'hA000);
        repeat (3) tick();
        check("t1_valid_early", port_f.read_data_valid, 0);
        check("t1_empty_early", port_f.empty, 1);
        tick();
        check("t1_valid",  port_f.read_data_valid, 1);
        check("t1_data",   port_f.read_data, 16'hA000);
        check("t1_empty",  port_f.empty, 0);
        check("t1_level",  port_f.read_level, exp_level(1));
        check("t1_almost", port_f.almost_empty, exp_almost(1, 1'b0));
        port_f.read_ready = 1'b1;
        tick();
        port_f.read_ready = 1'b0;
        check("t1_drained_empty", port_f.empty, 1);
        check("t1_drained_level", port_f.read_level, exp_level(0));

        // 2: full memory drained back to back.
        for (int i = 0; i < DEPTH; i++) write_fwft(16'hB000 + 16'(i));
        port_f.read_ready = 1'b1;
        got = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 40 && got < DEPTH; cyc++) begin
            if (port_f.read_data_valid) begin
                check($sformatf("t2_word%0d", got), port_f.read_data, 16'hB000 + 16'(got));
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            tick();
        end
        port_f.read_ready = 1'b0;
        check("t2_count",        got, DEPTH);
        check("t2_back_to_back", last - first, DEPTH - 1);
        check("t2_empty",        port_f.empty, 1);
        check("t2_level",        port_f.read_level, exp_level(0));

        // 3: pointer wrap after a fresh reset.
        reset_n = 1'b0;
        wptr_f = 0; wgray_f = '0; wptr_s = 0; wgray_s = '0;
        tick();
        reset_n = 1'b1;
        tick();
        addr_log.delete();
        port_f.read_ready = 1'b1;
        got = 0; written = 0; gray_checked = 1'b0;
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            if (port_f.read_data_valid) begin
                check($sformatf("t3_word%0d", got), port_f.read_data, 16'hC000 + 16'(got));
                got++;
            end
            if (written < 20 && (written - got) < 6) begin
                write_fwft(16'hC000 + 16'(written));
                written++;
            end
            tick();
            if (!gray_checked && addr_log.size() == 15) begin
                check("t3_gray_ptr15", rgray_f, 4'b1000);
                gray_checked = 1'b1;
            end
        end
        port_f.read_ready = 1'b0;
        check("t3_count",      got, 20);
        check("t3_gray_seen",  gray_checked, 1);
        check("t3_addr_count", addr_log.size(), 20);
        for (int i = 0; i < 20 && i < addr_log.size(); i++)
            check($sformatf("t3_addr%0d", i), addr_log[i], i % DEPTH);

        // 4: standard mode, request while empty.
        port_s.read_ready = 1'b1;
        #1;
        check("t4_no_strobe", mre_s, 0);
        tick();
        port_s.read_ready = 1'b0;
        check("t4_underflow", port_s.underflow, 1);
        check("t4_valid",     port_s.read_data_valid, 0);
        check("t4_empty",     port_s.empty, 1);
        tick();
        check("t4_underflow_clear", port_s.underflow, 0);
        check("t4_valid_after",     port_s.read_data_valid, 0);

        // Standard mode normal read: valid pulses two clocks after the request.
        write_std(16'hD000);
        write_std(16'hD001);
        repeat (3) tick();
        check("t4b_empty", port_s.empty, 0);
        check("t4b_level", port_s.read_level, exp_level(2));
        port_s.read_ready = 1'b1;
        #1;
        check("t4b_strobe", mre_s, 1);
        check("t4b_addr",   addr_s, 0);
        tick();
        port_s.read_ready = 1'b0;
        check("t4b_valid_wait", port_s.read_data_valid, 0);
        check("t4b_level_dec",  port_s.read_level, exp_level(1));
        tick();
        check("t4b_valid", port_s.read_data_valid, 1);
        check("t4b_data",  port_s.read_data, 16'hD000);
        tick();
        check("t4b_valid_pulse", port_s.read_data_valid, 0);
        check("t4b_data_hold",   port_s.read_data, 16'hD000);

        // 5: backpressure holds word0, then three consecutive transfers.
        for (int i = 0; i < 3; i++) write_fwft(16'hE000 + 16'(i));
        repeat (6) tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_hold_valid%0d", i), port_f.read_data_valid, 1);
            check($sformatf("t5_hold_data%0d", i),  port_f.read_data, 16'hE000);
            tick();
        end
        check("t5_level",  port_f.read_level, exp_level(3));
        check("t5_almost", port_f.almost_empty, exp_almost(3, 1'b0));
        port_f.read_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t5_valid%0d", i), port_f.read_data_valid, 1);
            check($sformatf("t5_data%0d", i),  port_f.read_data, 16'hE000 + 16'(i));
            tick();
        end
        port_f.read_ready = 1'b0;
        check("t5_empty", port_f.empty, 1);

        // 6: asynchronous reset in mid-stream.
        for (int i = 0; i < 5; i++) write_fwft(16'hF000 + 16'(i));
        repeat (8) tick();
        check("t6_level_before",  port_f.read_level, exp_level(5));
        check("t6_almost_before", port_f.almost_empty, exp_almost(5, 1'b0));
        check("t6_valid_before",  port_f.read_data_valid, 1);
        #2;
        reset_n = 1'b0;
        wptr_f = 0; wgray_f = '0; wptr_s = 0; wgray_s = '0;
        #1;
        check("t6_valid_async",  port_f.read_data_valid, 0);
        check("t6_empty_async",  port_f.empty, 1);
        check("t6_level_async",  port_f.read_level, 0);
        check("t6_almost_async", port_f.almost_empty, 1);
        check("t6_rgray_async",  rgray_f, 0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("t6_empty_after", port_f.empty, 1);
        check("t6_level_after", port_f.read_level, 0);
        check("t6_valid_after", port_f.read_data_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
